// File: rtl/mux_scan_n_pkg.sv
// mux_scan_n_pkg: shared mode encodings and a width helper for the scanning mux
package mux_scan_n_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Ceiling log2 usable in parameter expressions; returns 0 for n <= 1
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_n_rr.sv
// rr_next_ch: circular first-one search over a channel mask starting at a given index
module rr_next_ch #(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic [CHANNELS-1:0] mask,
    input  logic [SEL_W-1:0]    start,
    output logic [SEL_W-1:0]    idx,
    output logic                found
);

    // start + off folded back into 0..CHANNELS-1; start is always a legal index
    function automatic logic [SEL_W-1:0] wrap(input logic [SEL_W-1:0] s, input int off);
        int t;
        t = int'(s) + off;
        return SEL_W'(t >= CHANNELS ? t - CHANNELS : t);
    endfunction

    // Walk offsets from farthest to nearest so the nearest set bit wins
    always_comb begin
        idx   = '0;
        found = |mask;
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (mask[wrap(start, i)]) idx = wrap(start, i);
    end

endmodule

// File: rtl/mux_scan_n.sv
// mux_scan_n: registered N:1 mux with manual/auto-scan channel choice and a valid/ready output
module mux_scan_n
    import mux_scan_n_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = clog2_f(CHANNELS),
    parameter int HOLD     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] inData,
    input  logic [SEL_W-1:0]          inS,
    input  logic [CHANNELS-1:0]       inMask,
    input  logic                      inMode,
    input  logic                      inEn,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          Y,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    output logic                      out_err
);

    localparam int DCNT_W = (HOLD > 1) ? clog2_f(HOLD) : 1;

    logic [WIDTH-1:0]  y_q, y_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              mode_q, mode_d;

    logic [SEL_W-1:0]  scan_ch, sel_ch;
    logic              scan_found, man_err, resolved, slot_free, capture, mode_chg, scan;
    logic [DCNT_W-1:0] dcnt_eff;
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  terms [CHANNELS];

    rr_next_ch #(
        .CHANNELS(CHANNELS),
        .SEL_W   (SEL_W)
    ) u_rr (
        .mask (inMask),
        .start(ptr_q),
        .idx  (scan_ch),
        .found(scan_found)
    );

    assign scan      = inMode == MODE_SCAN;
    assign sel_ch    = scan ? scan_ch : inS;
    assign man_err   = int'(inS) >= CHANNELS;
    assign resolved  = scan ? scan_found : 1'b1;
    assign slot_free = !valid_q || out_ready;
    assign capture   = inEn && slot_free && resolved;
    assign mode_chg  = inMode != mode_q;
    assign dcnt_eff  = mode_chg ? '0 : dcnt_q;

    // Each channel contributes only when selected, so an out-of-range select reads as zero
    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_term
            assign terms[g] = (sel_ch == SEL_W'(g)) ? inData[g*WIDTH +: WIDTH] : '0;
        end
    endgenerate

    // OR together the gated channel terms
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) sel_data = sel_data | terms[i];
    end

    // Next state: capture loads the output slot; scan captures also advance the dwell/pointer
    always_comb begin
        mode_d  = inMode;
        y_d     = y_q;
        ch_d    = ch_q;
        err_d   = err_q;
        ptr_d   = ptr_q;
        dcnt_d  = dcnt_eff;
        valid_d = slot_free ? capture : valid_q;
        if (capture) begin
            y_d   = sel_data;
            ch_d  = sel_ch;
            err_d = !scan && man_err;
            if (scan) begin
                ptr_d  = (int'(dcnt_eff) == HOLD - 1)
                       ? ((int'(scan_ch) == CHANNELS - 1) ? '0 : scan_ch + 1'b1)
                       : scan_ch;
                dcnt_d = (int'(dcnt_eff) == HOLD - 1) ? '0 : dcnt_eff + 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously so a pending sample is dropped on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
            dcnt_q  <= '0;
            mode_q  <= MODE_MANUAL;
        end else begin
            y_q     <= y_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
            dcnt_q  <= dcnt_d;
            mode_q  <= mode_d;
        end
    end

    assign Y         = y_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: directed checks of manual select, range error, scanning, masking, backpressure and reset
module tb_mux_scan_n;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, rdy = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] a_d = '0, b_d = '0, a_m = '0, b_m = '0;
    logic [5:0] c_d = '0, c_m = '0;
    logic [2:0] a_s = '0, b_s = '0, c_s = '0;
    logic       a_md = 1'b0, b_md = 1'b0, c_md = 1'b0;
    logic       a_y, b_y, c_y, a_v, b_v, c_v, a_e, b_e, c_e;
    logic [2:0] a_ch, b_ch, c_ch;

    int total = 0, bad = 0;

    mux_scan_n #(.WIDTH(1), .CHANNELS(8), .HOLD(2)) u_a (
        .clk(clk), .rst_n(rst_n), .inData(a_d), .inS(a_s), .inMask(a_m), .inMode(a_md),
        .inEn(en), .out_ready(rdy), .Y(a_y), .out_ch(a_ch), .out_valid(a_v), .out_err(a_e));

    mux_scan_n #(.WIDTH(1), .CHANNELS(8), .HOLD(1)) u_b (
        .clk(clk), .rst_n(rst_n), .inData(b_d), .inS(b_s), .inMask(b_m), .inMode(b_md),
        .inEn(en), .out_ready(rdy), .Y(b_y), .out_ch(b_ch), .out_valid(b_v), .out_err(b_e));

    mux_scan_n #(.WIDTH(1), .CHANNELS(6), .HOLD(4)) u_c (
        .clk(clk), .rst_n(rst_n), .inData(c_d), .inS(c_s), .inMask(c_m), .inMode(c_md),
        .inEn(en), .out_ready(rdy), .Y(c_y), .out_ch(c_ch), .out_valid(c_v), .out_err(c_e));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    int e4 [5] = '{1, 5, 7, 1, 5};
    int ex;

    initial begin
        #12;
        chk("rst_y", a_y, 0);
        chk("rst_ch", a_ch, 0);
        chk("rst_v", a_v, 0);
        chk("rst_e", a_e, 0);
        @(negedge clk) rst_n = 1'b1;
        en  = 1'b1;
        rdy = 1'b1;

        // T1: manual sweep
        a_d  = 8'b1001_0110;
        a_md = 1'b0;
        for (int s = 0; s < 8; s++) begin
            a_s = 3'(s);
            step();
            chk("t1_y", a_y, a_d[s]);
            chk("t1_ch", a_ch, s);
            chk("t1_v", a_v, 1);
            chk("t1_e", a_e, 0);
        end

        // T2: out-of-range select on a 6-channel instance, then the top legal channel
        c_d = 6'b10_0000;
        c_s = 3'd7;
        step();
        chk("t2_y", c_y, 0);
        chk("t2_ch", c_ch, 7);
        chk("t2_e", c_e, 1);
        chk("t2_v", c_v, 1);
        c_s = 3'd5;
        step();
        chk("t2_y5", c_y, 1);
        chk("t2_e5", c_e, 0);
        chk("t2_ch5", c_ch, 5);

        // T3: full-mask scan, two samples per channel, with wrap
        do_reset();
        a_md = 1'b1;
        a_m  = 8'hFF;
        a_d  = 8'b1001_0110;
        for (int i = 0; i < 18; i++) begin
            step();
            ex = (i / 2) % 8;
            chk("t3_ch", a_ch, ex);
            chk("t3_y", a_y, a_d[ex]);
        end

        // T4: sparse mask, one sample per channel, then empty mask
        do_reset();
        b_md = 1'b1;
        b_m  = 8'b1010_0010;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_ch", b_ch, e4[i]);
            chk("t4_v", b_v, 1);
        end
        b_m = 8'h00;
        step();
        chk("t4_vdrop", b_v, 0);
        chk("t4_chhold", b_ch, 5);

        // T5: backpressure freezes output and scan state
        do_reset();
        a_md = 1'b1;
        a_m  = 8'hFF;
        a_d  = 8'b1001_0110;
        step(); chk("t5_pre0", a_ch, 0);
        step(); chk("t5_pre1", a_ch, 0);
        step(); chk("t5_pre2", a_ch, 1);
        rdy = 1'b0;
        a_d = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_frz_ch", a_ch, 1);
            chk("t5_frz_y", a_y, 1);
            chk("t5_frz_v", a_v, 1);
        end
        rdy = 1'b1;
        a_d = 8'b1001_0110;
        step(); chk("t5_res0", a_ch, 1);
        step(); chk("t5_res1", a_ch, 2);
        step(); chk("t5_res2", a_ch, 2);
        step(); chk("t5_res3", a_ch, 3);

        // T6: mode toggle mid-dwell clears dwell count but keeps pointer; async reset
        do_reset();
        a_md = 1'b1;
        a_m  = 8'hFF;
        a_d  = 8'hFF;
        for (int i = 0; i < 7; i++) step();
        chk("t6_pre", a_ch, 3);
        a_md = 1'b0;
        a_s  = 3'd6;
        step();
        chk("t6_man", a_ch, 6);
        a_md = 1'b1;
        step(); chk("t6_back0", a_ch, 3);
        step(); chk("t6_back1", a_ch, 3);
        step(); chk("t6_back2", a_ch, 4);
        chk("t6_y1", a_y, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_y", a_y, 0);
        chk("t6_rst_ch", a_ch, 0);
        chk("t6_rst_v", a_v, 0);
        chk("t6_rst_e", a_e, 0);
        @(negedge clk) rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
